// File: rtl/attn_pkg.sv
// Shared types and elaboration-time helpers for the sequence attention core.
package attn_pkg;

  localparam int FRAC      = 8;
  localparam int LUT_DEPTH = 64;

  typedef enum logic [2:0] {IDLE, LOAD, EXP_ACC, NORM, DONE} attn_state_t;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // round(2^frac * exp(-idx/8)) in integer arithmetic; 947573834 = exp(-1/8) * 2^30.
  function automatic int exp_entry(input int idx, input int frac);
    longint r;
    r = longint'(1) <<< 30;
    for (int i = 0; i < idx; i++) r = (r * 64'sd947573834) >>> 30;
    return int'(((r <<< frac) + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/attn_exp_lut.sv
// Combinational exp table: e = exp(x) for x <= 0, unsigned with 1.0 = 2^FRAC.
module attn_exp_lut #(
  parameter int DW   = 16,
  parameter int FRAC = attn_pkg::FRAC
) (
  input  logic [DW-1:0] x,
  output logic [FRAC:0] e
);
  import attn_pkg::*;

  localparam int IW = $clog2(LUT_DEPTH);

  logic [FRAC:0] tbl [LUT_DEPTH];
  logic [DW:0]   mag;
  logic [DW:0]   sh;
  logic [IW-1:0] idx;

  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_tbl
    localparam int EV = exp_entry(i, FRAC);
    assign tbl[i] = EV[FRAC:0];
  end

  // One table step is 1/8 in the exponent, so the index drops FRAC-3 fraction bits.
  always_comb begin
    mag = -{x[DW-1], x};
    sh  = mag >> (FRAC - 3);
    idx = (sh > (DW+1)'(LUT_DEPTH - 1)) ? IW'(LUT_DEPTH - 1) : sh[IW-1:0];
  end

  assign e = tbl[idx];

endmodule

// File: rtl/attention_seq_core.sv
// Single-head scaled dot-product attention over up to L streamed (key, value) pairs.
module attention_seq_core #(
  parameter int D           = 4,
  parameter int L           = 4,
  parameter int DW          = 16,
  parameter int FRAC        = attn_pkg::FRAC,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(L+1)-1:0]   len,
  input  logic [D-1:0][DW-1:0]     q,
  input  logic                     kv_valid,
  output logic                     kv_ready,
  input  logic [D-1:0][DW-1:0]     k_in,
  input  logic [D-1:0][DW-1:0]     v_in,
  output logic                     busy,
  output logic                     done,
  output logic [D-1:0][DW-1:0]     y
);
  import attn_pkg::*;

  localparam int PW  = 2*DW + $clog2(D);
  localparam int EW  = FRAC + 1;
  localparam int SW  = EW + $clog2(L);
  localparam int AW  = DW + EW + 1 + $clog2(L);
  localparam int CW  = $clog2(((L > D) ? L : D) + 1);
  localparam int KIW = (L > 1) ? $clog2(L) : 1;
  localparam int DIW = (D > 1) ? $clog2(D) : 1;

  attn_state_t state, state_nxt;

  logic [CW-1:0]            len_q, len_eff, cnt;
  logic [D-1:0][DW-1:0]     q_q;
  logic signed [DW-1:0]     s_buf [L];
  logic [D-1:0][DW-1:0]     v_buf [L];
  logic signed [DW-1:0]     s_max;
  logic [SW-1:0]            sum;
  logic signed [AW-1:0]     acc  [D];
  logic signed [AW-1:0]     prod [D];

  logic [KIW-1:0]           kidx;
  logic [DIW-1:0]           didx;
  logic                     accept, last_k, last_d;
  logic signed [PW-1:0]     dot;
  logic signed [PW-1:0]     dot_sh;
  logic signed [DW-1:0]     score;
  logic signed [DW:0]       diff;
  logic [DW-1:0]            lut_x;
  logic [EW-1:0]            e;
  logic signed [AW-1:0]     quo;
  logic [DW-1:0]            y_elem;

  assign kidx     = cnt[KIW-1:0];
  assign didx     = cnt[DIW-1:0];
  assign accept   = (state == LOAD) && kv_valid;
  assign last_k   = (cnt == len_q - CW'(1));
  assign last_d   = (cnt == CW'(D - 1));
  assign len_eff  = (len == '0 || int'(len) > L) ? CW'(L) : CW'(len);
  assign kv_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Full-precision dot product, then scale and saturate to a score.
  always_comb begin
    dot = '0;
    for (int d = 0; d < D; d++)
      dot += {{(PW-DW){q_q[d][DW-1]}}, q_q[d]} * {{(PW-DW){k_in[d][DW-1]}}, k_in[d]};
    dot_sh = dot >>> (FRAC + SCALE_SHIFT);
    score  = DW'(sat_dw(64'(dot_sh), DW));
  end

  // s - max is never positive; clamp it into DW bits before the table lookup.
  always_comb begin
    diff  = {s_buf[kidx][DW-1], s_buf[kidx]} - {s_max[DW-1], s_max};
    lut_x = (diff[DW] != diff[DW-1]) ? {1'b1, {(DW-1){1'b0}}} : diff[DW-1:0];
  end

  attn_exp_lut #(.DW(DW), .FRAC(FRAC)) u_exp (
    .x (lut_x),
    .e (e)
  );

  always_comb begin
    for (int d = 0; d < D; d++)
      prod[d] = {{(AW-DW){v_buf[kidx][d][DW-1]}}, v_buf[kidx][d]} * {{(AW-EW){1'b0}}, e};
    quo    = acc[didx] / $signed({{(AW-SW){1'b0}}, sum});
    y_elem = DW'(sat_dw(64'(quo), DW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)            state_nxt = LOAD;
      LOAD:    if (accept && last_k) state_nxt = EXP_ACC;
      EXP_ACC: if (last_k)           state_nxt = NORM;
      NORM:    if (last_d)           state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt   <= '0;
      q_q   <= '0;
      s_max <= '0;
      sum   <= '0;
      y     <= '0;
      // NOTE: the buffers are reset too, so a run cut short by rst leaves no stale pairs behind.
      for (int i = 0; i < L; i++) begin
        s_buf[i] <= '0;
        v_buf[i] <= '0;
      end
      for (int d = 0; d < D; d++) acc[d] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_q <= len_eff;
          q_q   <= q;
          cnt   <= '0;
          sum   <= '0;
          s_max <= '0;
          for (int d = 0; d < D; d++) acc[d] <= '0;
        end
        LOAD: if (accept) begin
          s_buf[kidx] <= score;
          v_buf[kidx] <= v_in;
          if (cnt == '0 || score > s_max) s_max <= score;
          cnt <= last_k ? '0 : cnt + CW'(1);
        end
        EXP_ACC: begin
          sum <= sum + SW'(e);
          for (int d = 0; d < D; d++) acc[d] <= acc[d] + prod[d];
          cnt <= last_k ? '0 : cnt + CW'(1);
        end
        NORM: begin
          y[didx] <= y_elem;
          cnt     <= last_d ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
